// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// One outstanding transaction; data wins unless fetch has starved too long.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_BURST);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        streak_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              fetch_win;

    // Fetch only beats a pending data request once the streak is exhausted
    assign fetch_win = if_req_i &&
                       (!dm_req_i || streak_q == STREAK_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_win) begin
                    if_gnt_o = 1'b1;
                    state_d  = S_REQ;
                end else if (dm_req_i) begin
                    dm_gnt_o = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    if_rvalid_o = (owner_q == OWN_IF);
                    dm_rvalid_o = (owner_q == OWN_DM);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else if (if_gnt_o) begin
            streak_q <= '0;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            addr_q   <= if_addr_i;
            wdata_q  <= '0;
            be_q     <= '1;
        end else if (dm_gnt_o) begin
            owner_q  <= OWN_DM;
            we_q     <= dm_we_i;
            addr_q   <= dm_addr_i;
            wdata_q  <= dm_wdata_i;
            be_q     <= dm_be_i;
            if (!if_req_i) begin
                streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + 4'd1;
            end
        end
    end

    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o = dm_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Responses are checked against a queue of expected owner/data pairs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [3:0]  dm_be_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DATA_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req_i(if_req_i),
        .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i),
        .dm_we_i(dm_we_i),
        .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i),
        .dm_be_i(dm_be_i),
        .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"}, mem_req_o, 0);
        chk({tag, "_if_gnt"}, if_gnt_o, 0);
        chk({tag, "_dm_gnt"}, dm_gnt_o, 0);
        chk({tag, "_if_rvalid"}, if_rvalid_o, 0);
        chk({tag, "_dm_rvalid"}, dm_rvalid_o, 0);
        chk({tag, "_if_rdata"}, if_rdata_o, 0);
        chk({tag, "_dm_rdata"}, dm_rdata_o, 0);
    endtask

    task automatic resp(input logic [31:0] d);
        exp_t e;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        settle();
        chk("rsp_any", if_rvalid_o | dm_rvalid_o, 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow got=rvalid exp=none");
        end else begin
            e = sb.pop_front();
            chk("rsp_if_valid", if_rvalid_o, !e.own);
            chk("rsp_dm_valid", dm_rvalid_o, e.own);
            chk("rsp_if_rdata", if_rdata_o,
                e.own ? 32'h0 : e.data);
            chk("rsp_dm_rdata", dm_rdata_o,
                e.own ? e.data : 32'h0);
        end
        adv();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst = 1'b1;
        if_req_i = 0; if_addr_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_addr_i = 0;
        dm_wdata_i = 0; dm_be_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        adv();
        adv();
        settle();
        chk_quiet("reset");
        chk("reset_mem_addr", mem_addr_o, 0);
        chk("reset_mem_we", mem_we_o, 0);
        chk("reset_mem_be", mem_be_o, 0);
        chk("reset_mem_wdata", mem_wdata_o, 0);
        adv();
        rst = 1'b0;
        adv();

        // single fetch, zero wait
        if_req_i = 1; if_addr_i = 32'h100;
        settle();
        chk("f1_if_gnt", if_gnt_o, 1);
        chk("f1_dm_gnt", dm_gnt_o, 0);
        sb.push_back('{own: 1'b0, data: 32'hDEADBEEF});
        adv();
        if_req_i = 0; if_addr_i = 32'h555;
        mem_gnt_i = 1;
        settle();
        chk("f1_mem_req", mem_req_o, 1);
        chk("f1_mem_addr", mem_addr_o, 32'h100);
        chk("f1_mem_we", mem_we_o, 0);
        chk("f1_mem_be", mem_be_o, 4'hF);
        adv();
        mem_gnt_i = 0;
        resp(32'hDEADBEEF);
        settle();
        chk_quiet("f1_after");
        adv();

        // store with back-pressure
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h2000;
        dm_wdata_i = 32'h12345678; dm_be_i = 4'h3;
        settle();
        chk("st_dm_gnt", dm_gnt_o, 1);
        chk("st_if_gnt", if_gnt_o, 0);
        sb.push_back('{own: 1'b1, data: 32'hCAFE0001});
        adv();
        dm_req_i = 0; dm_we_i = 0; dm_addr_i = 32'hFFFF;
        dm_wdata_i = 32'h0; dm_be_i = 4'hC;
        for (int i = 0; i < 4; i++) begin
            mem_gnt_i = (i == 3);
            settle();
            chk("st_mem_req", mem_req_o, 1);
            chk("st_mem_we", mem_we_o, 1);
            chk("st_mem_addr", mem_addr_o, 32'h2000);
            chk("st_mem_wdata", mem_wdata_o, 32'h12345678);
            chk("st_mem_be", mem_be_o, 4'h3);
            adv();
        end
        mem_gnt_i = 0;
        settle();
        chk("st_wait_req", mem_req_o, 0);
        chk("st_wait_rv", dm_rvalid_o, 0);
        adv();
        resp(32'hCAFE0001);
        settle();
        chk("st_once", dm_rvalid_o, 0);
        adv();

        // simultaneous requests
        if_req_i = 1; if_addr_i = 32'h300;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h400;
        settle();
        chk("sim_dm_gnt", dm_gnt_o, 1);
        chk("sim_if_gnt", if_gnt_o, 0);
        sb.push_back('{own: 1'b1, data: 32'hAAAA0000});
        adv();
        dm_req_i = 0;
        mem_gnt_i = 1;
        settle();
        chk("sim_addr_d", mem_addr_o, 32'h400);
        chk("sim_req_ifg", if_gnt_o, 0);
        adv();
        mem_gnt_i = 0;
        resp(32'hAAAA0000);
        settle();
        chk("sim_if_gnt2", if_gnt_o, 1);
        chk("sim_dm_gnt2", dm_gnt_o, 0);
        sb.push_back('{own: 1'b0, data: 32'hBBBB0000});
        adv();
        if_req_i = 0;
        mem_gnt_i = 1;
        settle();
        chk("sim_addr_f", mem_addr_o, 32'h300);
        adv();
        mem_gnt_i = 0;
        resp(32'hBBBB0000);

        // starvation bound: D D D D F repeating
        if_req_i = 1; if_addr_i = 32'h700;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h800;
        for (int k = 0; k < 10; k++) begin
            logic exp_f;
            exp_f = (k % 5 == 4);
            settle();
            chk("stv_if_gnt", if_gnt_o, exp_f);
            chk("stv_dm_gnt", dm_gnt_o, !exp_f);
            sb.push_back('{own: !exp_f,
                           data: 32'h5000_0000 + k});
            adv();
            mem_gnt_i = 1;
            settle();
            chk("stv_addr", mem_addr_o,
                exp_f ? 32'h700 : 32'h800);
            adv();
            mem_gnt_i = 0;
            resp(32'h5000_0000 + k);
        end
        if_req_i = 0; dm_req_i = 0;

        // reset during WAIT
        if_req_i = 1; if_addr_i = 32'h500;
        settle();
        chk("rw_if_gnt", if_gnt_o, 1);
        adv();
        if_req_i = 0;
        mem_gnt_i = 1;
        adv();
        mem_gnt_i = 0;
        rst = 1;
        adv();
        rst = 0;
        settle();
        chk_quiet("rw_after");
        chk("rw_mem_addr", mem_addr_o, 0);
        chk("rw_mem_be", mem_be_o, 0);
        adv();
        mem_rvalid_i = 1; mem_rdata_i = 32'h99;
        settle();
        chk_quiet("rw_late_rsp");
        adv();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        if_req_i = 1; if_addr_i = 32'h600;
        settle();
        chk("rw_new_gnt", if_gnt_o, 1);
        sb.push_back('{own: 1'b0, data: 32'h6060_6060});
        adv();
        if_req_i = 0;
        mem_gnt_i = 1;
        settle();
        chk("rw_new_addr", mem_addr_o, 32'h600);
        adv();
        mem_gnt_i = 0;
        resp(32'h6060_6060);

        // stray response in IDLE
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        settle();
        chk_quiet("stray");
        adv();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h900;
        settle();
        chk("stray_dm_gnt", dm_gnt_o, 1);
        sb.push_back('{own: 1'b1, data: 32'h0909_0909});
        adv();
        dm_req_i = 0;
        mem_gnt_i = 1;
        settle();
        chk("stray_req", mem_req_o, 1);
        chk("stray_addr", mem_addr_o, 32'h900);
        adv();
        mem_gnt_i = 0;
        resp(32'h0909_0909);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the instruction-fetch requester and the data (load/store) requester of the memory stage. It runs a grant/issue/wait state machine with one outstanding transaction. Data has priority, and a starvation counter bounds how long fetch can be locked out. It sits between the pipeline stages and the memory model or bus, and steers each response back to the requester that issued it.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` byte enables.
- `MAX_DATA_BURST`, default 4: consecutive data grants allowed while fetch is pending; range 1..15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req_i`  in  1  fetch request; held until `if_gnt_o`.
- `if_addr_i`  in  ADDR_W  fetch address.
- `if_gnt_o`  out  1  fetch request accepted (1-cycle pulse).
- `if_rvalid_o`  out  1  fetch read data valid (1-cycle pulse).
- `if_rdata_o`  out  DATA_W  fetch read data.
- `dm_req_i`  in  1  data request; held until `dm_gnt_o`.
- `dm_we_i`  in  1  1 = store, 0 = load.
- `dm_addr_i`  in  ADDR_W  data address.
- `dm_wdata_i`  in  DATA_W  store data.
- `dm_be_i`  in  DATA_W/8  store byte enables.
- `dm_gnt_o`  out  1  data request accepted (1-cycle pulse).
- `dm_rvalid_o`  out  1  load data valid, or store completion (1-cycle pulse).
- `dm_rdata_o`  out  DATA_W  load data.
- `mem_req_o`  out  1  request to memory; held until `mem_gnt_i`.
- `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`  out  request fields; registered and stable while `mem_req_o` is high.
- `mem_gnt_i`  in  1  memory accepted the request.
- `mem_rvalid_i`  in  1  response valid.
- `mem_rdata_i`  in  DATA_W  response data.

## Operation
- State machine: IDLE, REQ, WAIT.
- **IDLE**
  - If any request is present, the winner is chosen combinationally and its `*_gnt_o` is asserted that cycle.
  - The winner's fields and an `owner` bit are latched, then the state goes to REQ.
  - When fetch wins, `mem_we_o` = 0 and `mem_be_o` = all ones.
- **REQ**
  - `mem_req_o` = 1.
  - When `mem_gnt_i` = 1, go to WAIT.
- **WAIT**
  - `mem_req_o` = 0.
  - When `mem_rvalid_i` = 1, pulse the owner's `*_rvalid_o` for that cycle. `*_rdata_o` is driven combinationally from `mem_rdata_i`.
  - Then go to IDLE.
  - Stores also wait for `mem_rvalid_i` as their completion acknowledge.
- **Arbitration**
  - Data wins by default.
  - `streak` is a 4-bit counter. It increments on each data grant made while `if_req_i` = 1, saturating at `MAX_DATA_BURST`.
  - When `streak` = `MAX_DATA_BURST` and `if_req_i` = 1, fetch wins.
  - A fetch grant clears `streak`.
  - A data grant with `if_req_i` = 0 also clears `streak`.
- **Ignored inputs**
  - `mem_rvalid_i` in IDLE or REQ: no `*_rvalid_o` is produced, and no state change occurs.
  - `mem_gnt_i` outside REQ.
- **Output defaults**
  - `*_rdata_o` = 0 whenever the matching `*_rvalid_o` = 0.

## Timing
- **Reset.** `rst` applies on the clock edge. State = IDLE, `streak` = 0, `owner` = fetch. All `mem_*` outputs = 0, both `*_gnt_o` = 0, both `*_rvalid_o` = 0.
- **Reset mid-transaction.** The transaction is abandoned and `mem_req_o` is 0 in the cycle after the reset edge. A response that arrives later lands in IDLE and is dropped.
- **Minimum round trip.**
  - Cycle 0: request present, `gnt` pulse.
  - Cycle 1: `mem_req_o` = 1, with `mem_gnt_i` = 1.
  - Cycle 2: WAIT, with `mem_rvalid_i` = 1, so `*_rvalid_o` = 1.
- **Back-to-back.** The next grant comes no earlier than the cycle after the response, giving a 3-cycle minimum per transaction. No bubble beyond that.
- **Simultaneous requests in IDLE.** Exactly one `gnt` is pulsed. The loser keeps its request and competes in the next IDLE.
- **Request-field sampling.** Fields are sampled only in the grant cycle. Changes after the grant do not affect the issued request.
- **Memory back-pressure.** `mem_gnt_i` low holds REQ indefinitely. `mem_*` fields stay constant during the hold.

## Test plan
- **Single fetch, zero wait.**
  - Stimulus: `if_req_i` = 1, `if_addr_i` = 0x100; memory grants immediately and returns 0xDEADBEEF one cycle later.
  - Required: `if_gnt_o` at cycle 0, `mem_req_o` at cycle 1 with `mem_addr_o` = 0x100 and `mem_we_o` = 0, `if_rvalid_o` at cycle 2 with `if_rdata_o` = 0xDEADBEEF, `dm_rvalid_o` never asserted.
- **Store with back-pressure.**
  - Stimulus: `dm_we_i` = 1, `dm_addr_i` = 0x2000, `dm_wdata_i` = 0x12345678, `dm_be_i` = 0x3; `mem_gnt_i` held low for 3 cycles.
  - Required: `mem_req_o` and all fields stable across 4 cycles; `dm_rvalid_o` pulses once on the acknowledge.
- **Simultaneous requests.**
  - Stimulus: both requests asserted at the same cycle.
  - Required: data granted first, fetch granted at the next IDLE; responses routed to the correct owner (data 0xAAAA0000, fetch 0xBBBB0000).
- **Starvation bound.**
  - Stimulus: `MAX_DATA_BURST` = 4; both requests held continuously.
  - Required: grant sequence D, D, D, D, F, D, D, D, D, F.
- **Reset during WAIT.**
  - Stimulus: `rst` pulsed for 1 cycle while in WAIT; `mem_rvalid_i` = 1 two cycles later.
  - Required: all outputs 0 after reset; no `*_rvalid_o` pulse; a new fetch then completes normally.
- **Stray response.**
  - Stimulus: `mem_rvalid_i` = 1 while in IDLE.
  - Required: no `*_rvalid_o`; state unchanged.
